// File: rtl/debug_display_scanner_if.sv
// Probe/display bus of the debug display scanner.
// master: probe/control side, drives the channel words and the selection/mode controls
//         and reads back the display word.
// slave : the scanner itself.
// Signals:
//   Channel_Data      packed probe words, channel k at [k*WIDTH +: WIDTH]
//   Display_Select    manual channel index
//   Auto_Scan         1 = auto-scan, 0 = manual
//   Step              single-cycle advance pulse (auto-scan)
//   Freeze            level, hold the displayed word
//   Display_Blank     level, show the blank pattern
//   HexDisplay32Bits  registered display word
//   Current_Channel   index of the channel being displayed
//   Frozen            output is a held snapshot
interface debug_display_scanner_if #(
  parameter int unsigned CHANNELS = 22,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SEL_W    = 5
);
  logic [CHANNELS*WIDTH-1:0] Channel_Data;
  logic [SEL_W-1:0]          Display_Select;
  logic                      Auto_Scan;
  logic                      Step;
  logic                      Freeze;
  logic                      Display_Blank;
  logic [WIDTH-1:0]          HexDisplay32Bits;
  logic [SEL_W-1:0]          Current_Channel;
  logic                      Frozen;

  modport master (
    output Channel_Data, Display_Select, Auto_Scan, Step, Freeze, Display_Blank,
    input  HexDisplay32Bits, Current_Channel, Frozen
  );

  modport slave (
    input  Channel_Data, Display_Select, Auto_Scan, Step, Freeze, Display_Blank,
    output HexDisplay32Bits, Current_Channel, Frozen
  );
endinterface

// File: rtl/debug_display_scanner.sv
// Debug display selector: picks one of CHANNELS probe words for the HEX bank, either from a
// manual select or by auto-scanning on a dwell timer, with freeze, single-step, blanking and
// an error pattern for out-of-range manual selects. All outputs are registered.
// Ports:
//   Clock   sole clock, rising edge
//   Reset   asynchronous, active-high, clears all state
//   dbg_io  probe/display bus (slave side), see debug_display_scanner_if
module debug_display_scanner #(
  parameter int unsigned CHANNELS  = 22,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEL_W     = 5,
  parameter int unsigned DWELL     = 50000000,
  parameter logic [15:0] BLANK_PAT = 16'h0FF0,
  parameter logic [15:0] ERR_PAT   = 16'hDEDE
) (
  input  logic                    Clock,
  input  logic                    Reset,
  debug_display_scanner_if.slave  dbg_io
);

  localparam int unsigned CntW = $clog2(DWELL + 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(DWELL - 1);
  localparam logic [SEL_W-1:0] ChanLast = SEL_W'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] BlankWord = WIDTH'(BLANK_PAT);
  localparam logic [WIDTH-1:0] ErrWord   = WIDTH'(ERR_PAT);

  logic [WIDTH-1:0] hex_q, hex_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             frozen_q, frozen_d;
  logic             freeze_q;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Normal-path results, computed every cycle regardless of blank/freeze.
  logic [WIDTH-1:0] norm_word;
  logic [SEL_W-1:0] norm_chan;
  logic [SEL_W-1:0] norm_idx;
  logic [CntW-1:0]  norm_cnt;
  logic             sel_in_range;
  logic             freeze_rise;

  // Constant-bound loop keeps the mux safe for selects beyond the last channel.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] data,
                                            input logic [SEL_W-1:0]          sel);
    logic [WIDTH-1:0] word;
    word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) word = data[k*WIDTH +: WIDTH];
    end
    return word;
  endfunction

  always_comb begin
    sel_in_range = 32'(dbg_io.Display_Select) < CHANNELS;
    norm_word    = '0;
    norm_chan    = '0;
    norm_idx     = idx_q;
    norm_cnt     = '0;
    if (!dbg_io.Auto_Scan) begin
      norm_chan = dbg_io.Display_Select;
      norm_word = sel_in_range ? pick(dbg_io.Channel_Data, dbg_io.Display_Select) : ErrWord;
      // Preload the scan index so a switch to auto-scan starts from this channel.
      norm_idx  = sel_in_range ? dbg_io.Display_Select : '0;
      norm_cnt  = '0;
    end else begin
      norm_chan = idx_q;
      norm_word = pick(dbg_io.Channel_Data, idx_q);
      // Step and dwell expiry share one advance, so coinciding events move one channel.
      if (dbg_io.Step || (cnt_q == CntLast)) begin
        norm_idx = (idx_q == ChanLast) ? '0 : idx_q + 1'b1;
        norm_cnt = '0;
      end else begin
        norm_idx = idx_q;
        norm_cnt = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    freeze_rise = dbg_io.Freeze && !freeze_q;
    hex_d       = hex_q;
    chan_d      = chan_q;
    frozen_d    = frozen_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    if (dbg_io.Display_Blank) begin
      // Scanning keeps running underneath the blank pattern.
      hex_d    = BlankWord;
      chan_d   = norm_chan;
      frozen_d = 1'b0;
      idx_d    = norm_idx;
      cnt_d    = norm_cnt;
    end else if (freeze_rise) begin
      // Capture edge behaves like a normal update; holding starts on the next cycle.
      hex_d    = norm_word;
      chan_d   = norm_chan;
      frozen_d = 1'b1;
      idx_d    = norm_idx;
      cnt_d    = norm_cnt;
    end else if (dbg_io.Freeze) begin
      // Hold everything; Step is ignored and the dwell timer pauses.
    end else begin
      hex_d    = norm_word;
      chan_d   = norm_chan;
      frozen_d = 1'b0;
      idx_d    = norm_idx;
      cnt_d    = norm_cnt;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hex_q    <= '0;
      chan_q   <= '0;
      frozen_q <= 1'b0;
      freeze_q <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      hex_q    <= hex_d;
      chan_q   <= chan_d;
      frozen_q <= frozen_d;
      freeze_q <= dbg_io.Freeze;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dbg_io.HexDisplay32Bits = hex_q;
  assign dbg_io.Current_Channel  = chan_q;
  assign dbg_io.Frozen           = frozen_q;

endmodule

// File: tb/tb_debug_display_scanner.sv
// Self-checking bench for debug_display_scanner: directed scenarios plus randomized stimulus,
// compared against a behavioural model of the display rules.
module tb_debug_display_scanner;

  localparam int unsigned CH = 22;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned DW = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  debug_display_scanner_if #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW)) dbg_if ();

  debug_display_scanner #(
    .CHANNELS(CH), .WIDTH(W), .SEL_W(SW), .DWELL(DW),
    .BLANK_PAT(16'h0FF0), .ERR_PAT(16'hDEDE)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .dbg_io (dbg_if)
  );

  logic [31:0] chan_val [CH];

  always_comb begin
    dbg_if.Channel_Data = '0;
    for (int k = 0; k < int'(CH); k++) dbg_if.Channel_Data[k*W +: W] = chan_val[k];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic [31:0] m_hex;
  int          m_chan;
  bit          m_frozen;
  bit          m_prev_freeze;
  int          m_idx;
  int          m_cnt;

  task automatic model_reset();
    m_hex = '0; m_chan = 0; m_frozen = 0; m_prev_freeze = 0; m_idx = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int          sel;
    int          n_chan, n_idx, n_cnt;
    logic [31:0] n_word;
    bit          fr;
    sel = int'(dbg_if.Display_Select);
    fr  = dbg_if.Freeze;
    if (!dbg_if.Auto_Scan) begin
      n_chan = sel;
      n_cnt  = 0;
      if (sel < int'(CH)) begin
        n_word = chan_val[sel];
        n_idx  = sel;
      end else begin
        n_word = 32'h0000_DEDE;
        n_idx  = 0;
      end
    end else begin
      n_chan = m_idx;
      n_word = chan_val[m_idx];
      if (dbg_if.Step || (m_cnt + 1 == int'(DW))) begin
        n_idx = (m_idx + 1) % int'(CH);
        n_cnt = 0;
      end else begin
        n_idx = m_idx;
        n_cnt = m_cnt + 1;
      end
    end
    if (dbg_if.Display_Blank) begin
      m_hex = 32'h0000_0FF0; m_chan = n_chan; m_frozen = 0; m_idx = n_idx; m_cnt = n_cnt;
    end else if (fr && !m_prev_freeze) begin
      m_hex = n_word; m_chan = n_chan; m_frozen = 1; m_idx = n_idx; m_cnt = n_cnt;
    end else if (!fr) begin
      m_hex = n_word; m_chan = n_chan; m_frozen = 0; m_idx = n_idx; m_cnt = n_cnt;
    end
    m_prev_freeze = fr;
  endtask

  task automatic cycle();
    @(posedge Clock);
    if (Reset) model_reset();
    else model_edge();
    #1;
    chk("model_hex", dbg_if.HexDisplay32Bits, m_hex);
    chk("model_chan", 32'(dbg_if.Current_Channel), 32'(m_chan));
    chk("model_frozen", 32'(dbg_if.Frozen), 32'(m_frozen));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < int'(CH); k++) chan_val[k] = $urandom;
    dbg_if.Display_Select = '0;
    dbg_if.Auto_Scan      = 1'b0;
    dbg_if.Step           = 1'b0;
    dbg_if.Freeze         = 1'b0;
    dbg_if.Display_Blank  = 1'b0;
    model_reset();

    // Reset state.
    #2 Reset = 1'b1;
    #2;
    chk("rst_hex", dbg_if.HexDisplay32Bits, 32'h0);
    chk("rst_chan", 32'(dbg_if.Current_Channel), 32'h0);
    chk("rst_frozen", 32'(dbg_if.Frozen), 32'h0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // Manual select, in range and out of range.
    chan_val[7] = 32'h1234_5678;
    dbg_if.Display_Select = 5'd7;
    cycle();
    chk("man7_hex", dbg_if.HexDisplay32Bits, 32'h1234_5678);
    chk("man7_chan", 32'(dbg_if.Current_Channel), 32'd7);
    dbg_if.Display_Select = 5'd25;
    cycle();
    chk("err_hex", dbg_if.HexDisplay32Bits, 32'h0000_DEDE);
    chk("err_chan", 32'(dbg_if.Current_Channel), 32'd25);

    // Auto-scan from 0 through a full wrap.
    dbg_if.Display_Select = 5'd0;
    cycle();
    dbg_if.Auto_Scan = 1'b1;
    for (int i = 0; i < int'(CH * DW); i++) begin
      cycle();
      chk("scan_seq", 32'(dbg_if.Current_Channel), 32'(i / int'(DW)));
    end
    cycle();
    chk("scan_wrap", 32'(dbg_if.Current_Channel), 32'd0);

    // Step on the 2nd cycle of channel 3, then Step coinciding with dwell expiry.
    dbg_if.Auto_Scan = 1'b0;
    dbg_if.Display_Select = 5'd3;
    cycle();
    dbg_if.Auto_Scan = 1'b1;
    cycle();
    dbg_if.Step = 1'b1;
    cycle();
    chk("step_2nd_of_3", 32'(dbg_if.Current_Channel), 32'd3);
    dbg_if.Step = 1'b0;
    for (int i = 0; i < int'(DW); i++) begin
      cycle();
      chk("step_full4", 32'(dbg_if.Current_Channel), 32'd4);
    end
    cycle();
    chk("step_next5", 32'(dbg_if.Current_Channel), 32'd5);
    cycle();
    cycle();
    dbg_if.Step = 1'b1;
    cycle();
    dbg_if.Step = 1'b0;
    for (int i = 0; i < int'(DW); i++) begin
      cycle();
      chk("step_expiry_one", 32'(dbg_if.Current_Channel), 32'd6);
    end
    cycle();
    chk("step_expiry_next", 32'(dbg_if.Current_Channel), 32'd7);

    // Freeze on channel 5, change the live data, release and resume the dwell.
    dbg_if.Auto_Scan = 1'b0;
    dbg_if.Display_Select = 5'd5;
    chan_val[5] = 32'hAAAA_0001;
    cycle();
    dbg_if.Auto_Scan = 1'b1;
    cycle();
    dbg_if.Freeze = 1'b1;
    cycle();
    chk("frz_capture", dbg_if.HexDisplay32Bits, 32'hAAAA_0001);
    chk("frz_flag", 32'(dbg_if.Frozen), 32'd1);
    chan_val[5] = 32'hBBBB_0002;
    dbg_if.Step = 1'b1;
    repeat (10) cycle();
    dbg_if.Step = 1'b0;
    chk("frz_hold_hex", dbg_if.HexDisplay32Bits, 32'hAAAA_0001);
    chk("frz_hold_flag", 32'(dbg_if.Frozen), 32'd1);
    chk("frz_hold_chan", 32'(dbg_if.Current_Channel), 32'd5);
    dbg_if.Freeze = 1'b0;
    cycle();
    chk("frz_release_hex", dbg_if.HexDisplay32Bits, 32'hBBBB_0002);
    chk("frz_release_flag", 32'(dbg_if.Frozen), 32'd0);
    cycle();
    chk("frz_resume_dwell", 32'(dbg_if.Current_Channel), 32'd5);
    cycle();
    chk("frz_resume_next", 32'(dbg_if.Current_Channel), 32'd6);

    // Blank during auto-scan.
    dbg_if.Display_Blank = 1'b1;
    repeat (6) begin
      cycle();
      chk("blank_hex", dbg_if.HexDisplay32Bits, 32'h0000_0FF0);
      chk("blank_frozen", 32'(dbg_if.Frozen), 32'd0);
    end
    dbg_if.Display_Blank = 1'b0;
    repeat (10) cycle();

    // Asynchronous reset mid-freeze at a non-edge time.
    dbg_if.Freeze = 1'b1;
    cycle();
    cycle();
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_hex", dbg_if.HexDisplay32Bits, 32'h0);
    chk("async_rst_chan", 32'(dbg_if.Current_Channel), 32'h0);
    chk("async_rst_frozen", 32'(dbg_if.Frozen), 32'h0);
    cycle();
    cycle();
    @(negedge Clock);
    Reset = 1'b0;
    dbg_if.Freeze = 1'b0;
    dbg_if.Auto_Scan = 1'b0;
    dbg_if.Display_Select = 5'd2;
    cycle();
    chk("post_rst_sel2_hex", dbg_if.HexDisplay32Bits, chan_val[2]);
    chk("post_rst_sel2_chan", 32'(dbg_if.Current_Channel), 32'd2);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      dbg_if.Auto_Scan = ($urandom_range(0, 9) != 0);
      dbg_if.Step      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) dbg_if.Freeze = ~dbg_if.Freeze;
      if ($urandom_range(0, 24) == 0) dbg_if.Display_Blank = ~dbg_if.Display_Blank;
      if ($urandom_range(0, 3) == 0) dbg_if.Display_Select = SW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) chan_val[$urandom_range(0, CH - 1)] = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_display_scanner.md
# debug_display_scanner

Registered, parametrised debug display selector for the processor bring-up board. It picks one of CHANNELS packed WIDTH-bit probe words (PC, IR, RA..RY, CCR, enables, etc.) for the 7-segment HEX bank. Selection is either manual or auto-scan, where the block steps through channels on a dwell timer. It adds freeze (snapshot hold), single-step advance, blanking and an error pattern for out-of-range selects. The block sits between the datapath/control probe bus and the HEX decoder.

## Interface
- CHANNELS, 22, number of probe channels (>=2)
- WIDTH, 32, bits per channel and display word (>=16)
- SEL_W, 5, select/channel index width; 2**SEL_W >= CHANNELS
- DWELL, 50000000, clock cycles each channel is shown in auto-scan (>=1)
- BLANK_PAT, 16'h0FF0, zero-extended to WIDTH, shown while blanked
- ERR_PAT, 16'hDEDE, zero-extended to WIDTH, shown for out-of-range manual select

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Channel_Data  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- Display_Select  in  SEL_W  manual channel index
- Auto_Scan  in  1  1 = auto-scan mode, 0 = manual
- Step  in  1  single-cycle pulse; advances channel in auto-scan
- Freeze  in  1  level; hold the displayed word while high
- Display_Blank  in  1  level; show BLANK_PAT while high
- HexDisplay32Bits  out  WIDTH  registered display word
- Current_Channel  out  SEL_W  channel index currently displayed
- Frozen  out  1  high while output is a held snapshot

## Operation
- All outputs are registered. Reset values: HexDisplay32Bits = 0, Current_Channel = 0, Frozen = 0, dwell counter = 0, scan index = 0.
- Each cycle, the priority order is Blank > Freeze > normal.
- Blank: HexDisplay32Bits <= BLANK_PAT. Frozen <= 0. Scan index and dwell counter keep running. Current_Channel keeps tracking the normal selection.
- Freeze, on the first cycle with Freeze high (rising edge detected against a registered copy):
  - Frozen <= 1.
  - HexDisplay32Bits captures the normal-path word for that cycle.
- Freeze, on subsequent cycles while Freeze stays high:
  - HexDisplay32Bits and Current_Channel hold.
  - The dwell counter and scan index pause.
  - Step is ignored.
- On Freeze falling, Frozen <= 0 and the normal path resumes the next cycle. The dwell counter continues from its paused value.
- Manual mode (Auto_Scan = 0):
  - Current_Channel <= Display_Select.
  - If Display_Select < CHANNELS, HexDisplay32Bits <= channel[Display_Select]; otherwise HexDisplay32Bits <= ERR_PAT.
  - The dwell counter is held at 0.
  - The scan index is loaded with Display_Select when in range, and with 0 when out of range.
- Auto-scan mode (Auto_Scan = 1):
  - HexDisplay32Bits <= channel[scan index], and Current_Channel <= scan index.
  - The dwell counter increments each cycle. When it reaches DWELL-1, it goes to 0 and the scan index advances.
  - Advance rule: index + 1, wrapping from CHANNELS-1 to 0. ERR_PAT never appears in auto-scan.
- Step (auto-scan, not frozen): advances the scan index immediately and zeroes the dwell counter. A Step coinciding with dwell expiry advances by exactly one channel, not two.
- Mode switch manual -> auto: scanning starts from the last in-range manual channel, with dwell counter 0.
- Mode switch auto -> manual: takes effect the next cycle.
- Channel_Data is sampled live. Only the freeze snapshot is held.

## Timing
- One-cycle latency: a change on any input at edge n is visible on the outputs after edge n+1.
- In auto-scan, each channel is displayed for exactly DWELL cycles when there is no Step, Freeze or Blank.
- Freeze capture is the value the output would have shown on the edge at which Freeze is first seen high.
- Reset asserted mid-scan or mid-freeze clears outputs asynchronously. The first post-reset update happens on the first rising Clock after Reset deasserts.
- The dwell counter is ceil(log2(DWELL+1)) bits wide. It never exceeds DWELL-1.

## Test plan
- Reset, manual mode, CHANNELS=22: channel 7 = 32'h1234_5678, Display_Select = 7 -> one cycle later HexDisplay32Bits = 32'h1234_5678 and Current_Channel = 7. Select = 25 -> output = 32'h0000_DEDE and Current_Channel = 25.
- DWELL=4, Auto_Scan = 1 from index 0 -> Current_Channel sequence 0,0,0,0,1,1,1,1,… After channel 21 it wraps to 0, with 4 cycles per channel.
- DWELL=4, Step pulsed on the 2nd cycle of channel 3 -> channel 4 appears the next cycle and is displayed for a full 4 cycles. Step coinciding with dwell expiry -> advance by 1 only.
- Freeze raised while channel 5 = 32'hAAAA_0001, then channel 5 changed to 32'hBBBB_0002 and 10 cycles elapse -> output stays 32'hAAAA_0001, Frozen = 1, index unchanged. After Freeze drops -> output 32'hBBBB_0002, and the remaining dwell resumes.
- Display_Blank high during auto-scan -> output = 32'h0000_0FF0 and Frozen = 0. Current_Channel keeps advancing, and scanning continues correctly when blank is released.
- Reset asserted asynchronously mid-freeze at a non-edge time -> all outputs are 0 immediately. After release, manual select 2 shows channel 2 after one edge.
